logicnet_input_encoder: RTL and testbench
=========================================

// Module: logicnet_input_encoder
// PURPOSE
//  Streaming front end of the LogicNet classifier. It takes raw signed fixed-point features,
//  one per handshake, and quantizes each one to IN_BITS unsigned bits. It packs one full frame
//  into the flat input vector that the layer0 neuron LUTs slice from.
//  This is the writer side of the layer0 input bus: it sits between the feature DMA/parser and layer0.
// PARAMETERS
//  NUM_FEAT   49  features per frame (vector slots)
//  FEAT_W     16  width of signed input feature (two's complement)
//  IN_BITS    2   quantized bits per feature (layer0 input precision)
//  SHIFT      6   arithmetic right shift applied before bias (fractional bits dropped)
//  BIAS       2   signed offset added after shift (zero-point)
// PORTS
//  clk      in   1                   rising-edge clock
//  rst_n    in   1                   synchronous active-low reset
//  s_valid  in   1                   feature valid
//  s_ready  out  1                   encoder can accept feature
//  s_data   in   FEAT_W              signed feature value
//  s_last   in   1                   marks final feature of frame
//  m_valid  out  1                   packed vector valid
//  m_ready  in   1                   layer0 pipeline accepts vector
//  m_data   out  NUM_FEAT*IN_BITS    packed vector; feature i at [i*IN_BITS +: IN_BITS]
//  err_len  out  1                   one-cycle pulse: frame length != NUM_FEAT
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=COLLECT, idx=0, packed reg=0.
//   - m_valid=0, s_ready=0 during the reset cycle, err_len=0.
//   - Reset mid-frame or mid-EMIT discards everything.
//  Quantize, combinational on s_data:
//   - t = (s_data >>> SHIFT) + BIAS, evaluated signed at FEAT_W+2 bits.
//   - q = (t<0) ? 0 : (t>2^IN_BITS-1) ? 2^IN_BITS-1 : t[IN_BITS-1:0].
//  States:
//   - COLLECT: s_ready=1, m_valid=0.
//     - On s_valid&s_ready, q is written to slot idx.
//     - s_last=0 and idx<NUM_FEAT-1: idx++.
//     - s_last=1 and idx==NUM_FEAT-1: go to EMIT, idx=0.
//     - s_last=1 and idx<NUM_FEAT-1 (short frame): err_len=1 next cycle, packed reg=0, idx=0, stay in COLLECT.
//     - s_last=0 and idx==NUM_FEAT-1 (long frame): err_len=1 next cycle, packed reg=0, idx=0, go to DRAIN.
//   - EMIT: s_ready=0, m_valid=1.
//     - m_data is held stable until m_valid&m_ready.
//     - Then go to COLLECT; the packed reg is not cleared, because every slot is overwritten by the next frame.
//   - DRAIN: s_ready=1, m_valid=0.
//     - Accepted features are discarded.
//     - An accepted s_last=1 returns to COLLECT.
//  Latency and throughput:
//   - The last feature accepted at edge T gives m_valid=1 from T+1.
//   - A vector accepted at edge U gives s_ready=1 from U+1.
//   - Best-case period: NUM_FEAT+1 cycles per frame.
//  Handshake and stability rules:
//   - m_valid never drops without m_ready; m_data does not change while m_valid=1 and m_ready=0.
//   - s_ready does not depend combinationally on m_ready.
//  Error pulse: err_len is high for exactly one cycle per bad frame and is never asserted in EMIT.
//  Simultaneous s_valid with s_ready=0 (EMIT): the feature is not consumed; the source holds it.
// TESTING (NUM_FEAT=4, IN_BITS=2, SHIFT=6, BIAS=2 unless noted)
//  1. Quantizer corners:
//     - s_data = 0, 64, 200, -1, -64, -1000 gives q = 2, 3, 3(sat), 1, 1, 0(clamp).
//  2. Full frame 0,64,-64,-1000 with s_last on the 4th and m_ready=1:
//     - m_valid rises one cycle after the last handshake with m_data=8'b00_01_11_10.
//     - m_valid is high for exactly one cycle.
//  3. Backpressure: m_ready=0 for 10 cycles after m_valid.
//     - m_data is stable and s_ready=0 throughout; the vector is accepted on the m_ready pulse.
//     - s_ready=1 on the next cycle.
//  4. Short frame (s_last on the 2nd feature):
//     - err_len pulses once and m_valid stays 0.
//     - A following good frame packs correctly with no stale slots from the bad frame.
//  5. Long frame (6 features, s_last on the 6th):
//     - err_len pulses once after the 4th feature; the remaining 2 features are drained.
//     - No m_valid; the next frame is good.
//  6. rst_n=0 mid-frame (after 2 features), then a full frame:
//     - Output vector contains only the new frame; m_valid=0 during and after reset until the frame completes.

Source files
------------

// File: rtl/logicnet_input_encoder.sv
// LogicNet layer0 input encoder: quantizes signed features to IN_BITS each and packs
// one full frame into the flat layer0 input vector, flagging frames of the wrong length.
module logicnet_input_encoder #(
  parameter int unsigned NUM_FEAT = 49,
  parameter int unsigned FEAT_W   = 16,
  parameter int unsigned IN_BITS  = 2,
  parameter int unsigned SHIFT    = 6,
  parameter int          BIAS     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [FEAT_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_FEAT*IN_BITS-1:0]  m_data,
  output logic                         err_len
);

  localparam int unsigned IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned T_W   = FEAT_W + 2;
  localparam int unsigned Q_MAX = (1 << IN_BITS) - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic signed [FEAT_W-1:0] feat_s_c;
  logic signed [FEAT_W-1:0] feat_sh_c;
  logic signed [T_W-1:0]    t_c;
  logic [IN_BITS-1:0]  q_c;
  logic                accept_c;

  // Shift out fractional bits, add zero-point, then clamp into [0, 2^IN_BITS-1].
  always_comb begin
    feat_s_c  = s_data;
    feat_sh_c = feat_s_c >>> SHIFT;
    t_c       = {{2{feat_sh_c[FEAT_W-1]}}, feat_sh_c} + T_W'(BIAS);
    q_c       = t_c[IN_BITS-1:0];
    if (t_c[T_W-1]) begin
      q_c = '0;
    end else if ($unsigned(t_c) > T_W'(Q_MAX)) begin
      q_c = IN_BITS'(Q_MAX);
    end
  end

  assign accept_c = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= COLLECT;
      idx     <= '0;
      m_data  <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      err_len <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        COLLECT: begin
          s_ready <= 1'b1;
          if (accept_c) begin
            for (int i = 0; i < int'(NUM_FEAT); i++) begin
              if (idx == IDX_W'(i)) m_data[i*IN_BITS +: IN_BITS] <= q_c;
            end
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (s_last) begin
                state   <= EMIT;
                m_valid <= 1'b1;
                s_ready <= 1'b0;
              end else begin
                // Over-long frame: drop what we have and swallow the rest.
                err_len <= 1'b1;
                m_data  <= '0;
                state   <= DRAIN;
              end
            end else if (s_last) begin
              err_len <= 1'b1;
              m_data  <= '0;
              idx     <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        EMIT: begin
          // Every slot is rewritten by the next frame, so the vector is not cleared here.
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= COLLECT;
          end
        end
        DRAIN: begin
          s_ready <= 1'b1;
          if (accept_c && s_last) state <= COLLECT;
        end
        default: begin
          state   <= COLLECT;
          idx     <= '0;
          m_valid <= 1'b0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logicnet_input_encoder.sv
// Randomized and directed bench for logicnet_input_encoder against a frame-level
// behavioural model (NUM_FEAT=4, IN_BITS=2, SHIFT=6, BIAS=2).
module tb_logicnet_input_encoder;

  localparam int unsigned NUM_FEAT = 4;
  localparam int unsigned FEAT_W   = 16;
  localparam int unsigned IN_BITS  = 2;
  localparam int unsigned SHIFT    = 6;
  localparam int          BIAS     = 2;
  localparam int unsigned VEC_W    = NUM_FEAT * IN_BITS;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [VEC_W-1:0]  m_data;
  logic              err_len;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  bit rnd_mode = 0;

  logicnet_input_encoder #(
    .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .IN_BITS(IN_BITS), .SHIFT(SHIFT), .BIAS(BIAS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^SHIFT, add zero-point, clamp to the IN_BITS range.
  function automatic int quant(input int x);
    int d;
    int t;
    d = 1 << SHIFT;
    t = (x >= 0) ? (x / d) : -((-x + d - 1) / d);
    t = t + BIAS;
    if (t < 0) return 0;
    if (t > (1 << IN_BITS) - 1) return (1 << IN_BITS) - 1;
    return t;
  endfunction

  // Frame-level model: features collected in a queue, vector emitted on a correct-length frame.
  int               feats[$];
  bit               holding = 0;
  bit               draining = 0;
  bit               exp_ready = 0;
  bit               exp_mvalid = 0;
  bit               exp_err = 0;
  bit               acc;
  logic [VEC_W-1:0] exp_vec = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      feats.delete();
      holding   = 0;
      draining  = 0;
      exp_ready = 0;
      exp_err   = 0;
    end else begin
      acc     = s_valid && exp_ready;
      exp_err = 0;
      if (holding) begin
        if (m_ready) holding = 0;
      end else if (acc) begin
        if (draining) begin
          if (s_last) draining = 0;
        end else begin
          feats.push_back(quant(int'($signed(s_data))));
          if (feats.size() == int'(NUM_FEAT)) begin
            if (s_last) begin
              for (int i = 0; i < int'(NUM_FEAT); i++)
                exp_vec[i*IN_BITS +: IN_BITS] = IN_BITS'(feats[i]);
              holding = 1;
            end else begin
              exp_err  = 1;
              draining = 1;
            end
            feats.delete();
          end else if (s_last) begin
            exp_err = 1;
            feats.delete();
          end
        end
      end
      exp_ready = !holding;
    end
    exp_mvalid = holding;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", 64'(s_ready), 64'(exp_ready));
      chk("m_valid", 64'(m_valid), 64'(exp_mvalid));
      chk("err_len", 64'(err_len), 64'(exp_err));
      if (exp_mvalid) chk("m_data", 64'(m_data), 64'(exp_vec));
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      m_ready = ($urandom % 3) != 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one feature and hold it until accepted (bounded wait).
  task automatic send(input int v, input bit last);
    bit ok;
    ok      = 0;
    s_valid = 1'b1;
    s_data  = FEAT_W'(v);
    s_last  = last;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: feature %0d not accepted within 64 cycles", v);
    end
  endtask

  initial begin
    int  len;
    int  rst_at;
    int  kind;
    int  v;
    bit  did_rst;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    step();
    chk_en = 1;
    @(negedge clk);
    chk("reset s_ready", 64'(s_ready), 64'd0);
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset err_len", 64'(err_len), 64'd0);
    step();
    rst_n = 1'b1;

    // Full frame with immediate acceptance: one-cycle m_valid.
    m_ready = 1'b1;
    send(0, 0); send(64, 0); send(-64, 0); send(-1000, 1);
    @(negedge clk);
    chk("frame1 m_valid", 64'(m_valid), 64'd1);
    chk("frame1 m_data", 64'(m_data), 64'h1E);
    chk("frame1 s_ready", 64'(s_ready), 64'd0);
    step();
    @(negedge clk);
    chk("frame1 m_valid drop", 64'(m_valid), 64'd0);
    chk("frame1 s_ready back", 64'(s_ready), 64'd1);
    step();

    // Backpressure: vector held stable for 10 cycles, including saturation corners.
    m_ready = 1'b0;
    send(0, 0); send(64, 0); send(200, 0); send(-1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp m_valid", 64'(m_valid), 64'd1);
      chk("bp m_data", 64'(m_data), 64'h7E);
      chk("bp s_ready", 64'(s_ready), 64'd0);
      step();
    end
    m_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp released m_valid", 64'(m_valid), 64'd0);
    chk("bp released s_ready", 64'(s_ready), 64'd1);
    step();

    // Short frame, then a good frame that must not see its slots.
    send(200, 0); send(200, 1);
    @(negedge clk);
    chk("short err_len", 64'(err_len), 64'd1);
    chk("short m_valid", 64'(m_valid), 64'd0);
    step();
    @(negedge clk);
    chk("short err_len once", 64'(err_len), 64'd0);
    step();
    send(-1000, 0); send(0, 0); send(-1000, 0); send(0, 1);
    @(negedge clk);
    chk("after short m_data", 64'(m_data), 64'h88);
    step();

    // Long frame: error after the 4th feature, two more drained.
    send(0, 0); send(0, 0); send(0, 0); send(0, 0);
    @(negedge clk);
    chk("long err_len", 64'(err_len), 64'd1);
    step();
    send(0, 0); send(0, 1);
    @(negedge clk);
    chk("long drained m_valid", 64'(m_valid), 64'd0);
    chk("long drained err_len", 64'(err_len), 64'd0);
    step();
    send(200, 0); send(-1, 0); send(0, 0); send(64, 1);
    @(negedge clk);
    chk("after long m_data", 64'(m_data), 64'hE7);
    step();

    // Reset mid-frame discards the partial frame.
    send(200, 0); send(200, 0);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("midreset m_valid", 64'(m_valid), 64'd0);
    chk("midreset s_ready", 64'(s_ready), 64'd0);
    step();
    rst_n = 1'b1;
    send(0, 0); send(0, 0); send(0, 0); send(-64, 1);
    @(negedge clk);
    chk("after reset m_data", 64'(m_data), 64'h6A);
    step();

    // Random frames, lengths, gaps, backpressure and occasional resets.
    rnd_mode = 1;
    for (int f = 0; f < 200; f++) begin
      kind    = int'($urandom % 12);
      len     = (kind == 0) ? int'($urandom_range(1, 3)) :
                (kind == 1) ? int'($urandom_range(5, 7)) : int'(NUM_FEAT);
      rst_at  = (($urandom % 30) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      did_rst = 0;
      for (int k = 0; k < len && !did_rst; k++) begin
        if (k == rst_at) begin
          rst_n = 1'b0;
          step();
          rst_n = 1'b1;
          did_rst = 1;
        end else begin
          repeat ($urandom % 3) step();
          v = ($urandom % 2) ? int'($urandom_range(0, 800)) - 400
                             : int'($urandom % 65536) - 32768;
          send(v, k == len - 1);
        end
      end
    end
    rnd_mode = 0;
    step();
    m_ready = 1'b1;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
